// File: rtl/led_matrix_scanner_pkg.sv
// Shared geometry, state encoding and all-dark constants for the 5x7 LED matrix scanner.
package led_matrix_scanner_pkg;

    localparam int DATA_WIDTH    = 35;
    localparam int COLUNE_SIZE   = 7;
    localparam int TOTAL_COLUNES = 5;
    localparam int COL_W         = $clog2(TOTAL_COLUNES);

    localparam logic [COLUNE_SIZE-1:0]   ROW_DARK = 7'h7F;
    localparam logic [TOTAL_COLUNES-1:0] COL_DARK = 5'b11111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    // Active-low one-hot select for a column index.
    function automatic logic [TOTAL_COLUNES-1:0] col_select_n(input logic [COL_W-1:0] col);
        return ~(TOTAL_COLUNES'(1) << col);
    endfunction

endpackage

// File: rtl/led_matrix_scanner_dwell_timer.sv
// Down-counter that times one column's lit period; expire is high in the last lit cycle.
module led_matrix_scanner_dwell_timer #(
    parameter int DWELL_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expire
);

    localparam int CW = $clog2(DWELL_CYCLES + 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= CW'(DWELL_CYCLES);
        end else if (count_reg != '0) begin
            count_reg <= count_reg - CW'(1);
        end
    end

    // Loaded on the BLANK cycle, so a count of one marks the final SHOW cycle.
    assign expire = (count_reg == CW'(1));

endmodule

// File: rtl/led_matrix_scanner.sv
// Column-multiplexed 5x7 LED matrix driver with a double-buffered frame handshake.
module led_matrix_scanner
    import led_matrix_scanner_pkg::*;
#(
    parameter int DWELL_CYCLES = 50000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    frame_in,
    input  logic                     frame_valid,
    output logic                     frame_ready,
    output logic [COLUNE_SIZE-1:0]   row_out,
    output logic [TOTAL_COLUNES-1:0] col_sel_n,
    output logic                     frame_done
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(TOTAL_COLUNES - 1);

    state_t                   state_reg, state_next;
    logic [COL_W-1:0]         col_reg, col_next;
    logic [DATA_WIDTH-1:0]    shadow_reg, shadow_next;
    logic [DATA_WIDTH-1:0]    active_reg, active_next;
    logic                     shadow_full_reg, shadow_full_next;
    logic [COLUNE_SIZE-1:0]   row_out_reg, row_out_next;
    logic [TOTAL_COLUNES-1:0] col_sel_n_reg, col_sel_n_next;
    logic                     frame_done_reg, frame_done_next;
    logic                     dwell_expire;
    logic [COLUNE_SIZE-1:0]   col_rows [TOTAL_COLUNES];

    led_matrix_scanner_dwell_timer #(
        .DWELL_CYCLES(DWELL_CYCLES)
    ) dwell_timer (
        .clk   (clk),
        .reset (reset),
        .load  (state_reg == ST_BLANK),
        .expire(dwell_expire)
    );

    always_comb begin
        state_next       = state_reg;
        col_next         = col_reg;
        shadow_next      = shadow_reg;
        active_next      = active_reg;
        shadow_full_next = shadow_full_reg;
        frame_done_next  = 1'b0;

        // Accept needs an empty shadow and every swap needs a full one, so they never collide.
        if (frame_valid && !shadow_full_reg) begin
            shadow_next      = frame_in;
            shadow_full_next = 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (shadow_full_reg) begin
                    active_next      = shadow_reg;
                    shadow_full_next = 1'b0;
                    col_next         = '0;
                    state_next       = ST_BLANK;
                end
            end
            ST_BLANK: state_next = ST_SHOW;
            ST_SHOW: begin
                if (dwell_expire) begin
                    state_next = ST_BLANK;
                    if (col_reg == LAST_COL) begin
                        col_next        = '0;
                        frame_done_next = 1'b1;
                        if (shadow_full_reg) begin
                            active_next      = shadow_reg;
                            shadow_full_next = 1'b0;
                        end
                    end else begin
                        col_next = col_reg + COL_W'(1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < TOTAL_COLUNES; gi++) begin : g_col
            assign col_rows[gi] = active_next[gi*COLUNE_SIZE +: COLUNE_SIZE];
        end
    endgenerate

    // Outputs are decoded from the next state so they register on the same edge as the state.
    always_comb begin
        row_out_next   = ROW_DARK;
        col_sel_n_next = COL_DARK;
        if (state_next == ST_SHOW) begin
            row_out_next   = col_rows[col_next];
            col_sel_n_next = col_select_n(col_next);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            col_reg         <= '0;
            shadow_reg      <= '1;
            active_reg      <= '1;
            shadow_full_reg <= 1'b0;
            row_out_reg     <= ROW_DARK;
            col_sel_n_reg   <= COL_DARK;
            frame_done_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            col_reg         <= col_next;
            shadow_reg      <= shadow_next;
            active_reg      <= active_next;
            shadow_full_reg <= shadow_full_next;
            row_out_reg     <= row_out_next;
            col_sel_n_reg   <= col_sel_n_next;
            frame_done_reg  <= frame_done_next;
        end
    end

    assign frame_ready = !shadow_full_reg;
    assign row_out     = row_out_reg;
    assign col_sel_n   = col_sel_n_reg;
    assign frame_done  = frame_done_reg;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed, table-driven bench for led_matrix_scanner with a 4-cycle dwell.
module tb_led_matrix_scanner;
    import led_matrix_scanner_pkg::*;

    localparam int DW   = 4;
    localparam int HMAX = 1024;
    localparam int NVEC = 19;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [34:0] frame_in = '1;
    logic        frame_valid = 1'b0;
    logic        frame_ready;
    logic [6:0]  row_out;
    logic [4:0]  col_sel_n;
    logic        frame_done;

    led_matrix_scanner #(.DWELL_CYCLES(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_in   (frame_in),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .row_out    (row_out),
        .col_sel_n  (col_sel_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // cyc = number of the most recent rising edge; hist_*[n] holds outputs just after edge n.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [4:0] hist_col   [HMAX];
    logic [6:0] hist_row   [HMAX];
    logic       hist_done  [HMAX];
    logic       hist_ready [HMAX];

    always @(negedge clk) begin
        if (cyc < HMAX) begin
            hist_col[cyc]   <= col_sel_n;
            hist_row[cyc]   <= row_out;
            hist_done[cyc]  <= frame_done;
            hist_ready[cyc] <= frame_ready;
        end
    end

    typedef struct {
        int         off;
        logic [4:0] col;
        logic [6:0] row;
        logic       done;
        logic       ready;
    } vec_t;

    vec_t vecs [NVEC];

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, idx, act, exp);
        end else begin
            $display("ok   %s at cycle %0d: %h", name, idx, act);
        end
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset       = 1'b1;
        frame_valid = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic offer(input logic [34:0] f, output int k);
        @(negedge clk);
        frame_in    = f;
        frame_valid = 1'b1;
        k           = cyc + 1;
        @(negedge clk);
        frame_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        int          n;
        logic [34:0] map_frame;
        logic [34:0] frame_b;
        logic [34:0] frame_c;

        // Frame 0 (all lit) scanned from accept edge k; offsets are relative to k.
        vecs[0]  = '{0,  5'b11111, 7'h7F, 1'b0, 1'b0};
        vecs[1]  = '{1,  5'b11111, 7'h7F, 1'b0, 1'b1};
        vecs[2]  = '{2,  5'b11110, 7'h00, 1'b0, 1'b1};
        vecs[3]  = '{5,  5'b11110, 7'h00, 1'b0, 1'b1};
        vecs[4]  = '{6,  5'b11111, 7'h7F, 1'b0, 1'b1};
        vecs[5]  = '{7,  5'b11101, 7'h00, 1'b0, 1'b1};
        vecs[6]  = '{10, 5'b11101, 7'h00, 1'b0, 1'b1};
        vecs[7]  = '{11, 5'b11111, 7'h7F, 1'b0, 1'b1};
        vecs[8]  = '{12, 5'b11011, 7'h00, 1'b0, 1'b1};
        vecs[9]  = '{16, 5'b11111, 7'h7F, 1'b0, 1'b1};
        vecs[10] = '{17, 5'b10111, 7'h00, 1'b0, 1'b1};
        vecs[11] = '{21, 5'b11111, 7'h7F, 1'b0, 1'b1};
        vecs[12] = '{22, 5'b01111, 7'h00, 1'b0, 1'b1};
        vecs[13] = '{25, 5'b01111, 7'h00, 1'b0, 1'b1};
        vecs[14] = '{26, 5'b11111, 7'h7F, 1'b1, 1'b1};
        vecs[15] = '{27, 5'b11110, 7'h00, 1'b0, 1'b1};
        vecs[16] = '{31, 5'b11111, 7'h7F, 1'b0, 1'b1};
        vecs[17] = '{51, 5'b11111, 7'h7F, 1'b1, 1'b1};
        vecs[18] = '{52, 5'b11110, 7'h00, 1'b0, 1'b1};

        map_frame     = '1;
        map_frame[22] = 1'b0;
        frame_b       = '1;
        frame_b[0]    = 1'b0;
        frame_c       = '1;
        frame_c[1]    = 1'b0;

        // Reset held for 3 cycles, then idle with no frame offered.
        repeat (3) @(negedge clk);
        chk("rst_col", cyc, 32'(col_sel_n), 32'h1F);
        chk("rst_row", cyc, 32'(row_out), 32'h7F);
        chk("rst_ready", cyc, 32'(frame_ready), 32'h1);
        chk("rst_done", cyc, 32'(frame_done), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("idle_dark", cyc, {20'h0, col_sel_n, row_out}, {20'h0, 5'b11111, 7'h7F});
            chk("idle_flags", cyc, {30'h0, frame_ready, frame_done}, {30'h0, 1'b1, 1'b0});
        end

        // Single all-lit frame: table of scan timing.
        offer(35'h0, k);
        wait_to(k + 60);
        for (int i = 0; i < NVEC; i++) begin
            n = k + vecs[i].off;
            chk("scan_col", vecs[i].off, 32'(hist_col[n]), 32'(vecs[i].col));
            chk("scan_row", vecs[i].off, 32'(hist_row[n]), 32'(vecs[i].row));
            chk("scan_done", vecs[i].off, 32'(hist_done[n]), 32'(vecs[i].done));
            chk("scan_ready", vecs[i].off, 32'(hist_ready[n]), 32'(vecs[i].ready));
        end
        n = 0;
        for (int i = 1; i < 56; i++) n += int'(hist_done[k + i]);
        chk("done_pulses", k, 32'(n), 32'd2);

        // Pixel mapping: bit 22 is column d, row index 1.
        do_reset(2);
        offer(map_frame, k);
        wait_to(k + 27);
        n = 0;
        for (int i = 1; i <= 25; i++) begin
            if (hist_col[k + i] == 5'b10111) begin
                n++;
                chk("map_col_d", i, 32'(hist_row[k + i]), 32'h7D);
            end else if (hist_row[k + i] !== 7'h7F) begin
                chk("map_other", i, 32'(hist_row[k + i]), 32'h7F);
            end
        end
        chk("map_d_cycles", k, 32'(n), 32'd4);

        // Double buffer: B accepted during column b of A, then C held off by backpressure.
        do_reset(2);
        offer(35'h0, k);
        wait_to(k + 7);
        frame_in    = frame_b;
        frame_valid = 1'b1;
        @(negedge clk);
        chk("db_ready_low", cyc - k, 32'(frame_ready), 32'h0);
        frame_in = frame_c;
        repeat (10) @(negedge clk);
        frame_valid = 1'b0;
        wait_to(k + 60);
        chk("db_a_col_e", 22, {20'h0, hist_col[k + 22], hist_row[k + 22]}, {20'h0, 5'b01111, 7'h00});
        chk("db_ready_k25", 25, 32'(hist_ready[k + 25]), 32'h0);
        chk("db_done", 26, 32'(hist_done[k + 26]), 32'h1);
        chk("db_ready_k26", 26, 32'(hist_ready[k + 26]), 32'h1);
        chk("db_b_col_a", 27, {20'h0, hist_col[k + 27], hist_row[k + 27]}, {20'h0, 5'b11110, 7'h7E});
        chk("db_b_col_a_end", 30, 32'(hist_row[k + 30]), 32'h7E);
        chk("db_b_col_b", 32, {20'h0, hist_col[k + 32], hist_row[k + 32]}, {20'h0, 5'b11101, 7'h7F});
        chk("db_b_repeat", 52, {20'h0, hist_col[k + 52], hist_row[k + 52]}, {20'h0, 5'b11110, 7'h7E});
        n = 0;
        for (int i = 1; i < 60; i++) n += int'(hist_row[k + i] == 7'h7D);
        chk("bp_c_never_shown", k, 32'(n), 32'd0);

        // Reset during column c with a frame waiting in the shadow.
        do_reset(2);
        offer(35'h0, k);
        wait_to(k + 8);
        frame_in    = frame_b;
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        wait_to(k + 12);
        chk("mid_col_c", 12, {20'h0, col_sel_n, row_out}, {20'h0, 5'b11011, 7'h00});
        chk("mid_shadow_full", 12, 32'(frame_ready), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_out", 13, {20'h0, col_sel_n, row_out}, {20'h0, 5'b11111, 7'h7F});
        chk("mid_rst_flags", 13, {30'h0, frame_ready, frame_done}, {30'h0, 1'b1, 1'b0});
        wait_to(k + 60);
        n = 0;
        for (int i = 13; i < 60; i++) begin
            if (hist_col[k + i] !== 5'b11111 || hist_row[k + i] !== 7'h7F) n++;
        end
        chk("mid_stays_dark", k, 32'(n), 32'd0);

        // Recovery: a new frame after reset scans normally.
        offer(frame_b, k);
        wait_to(k + 4);
        chk("recover_col_a", 2, {20'h0, hist_col[k + 2], hist_row[k + 2]}, {20'h0, 5'b11110, 7'h7E});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/led_matrix_scanner.md
# led_matrix_scanner

Sequential driver for the 5x7 LED matrix. It sits at the output end of `map_decoder` and consumes the 35-bit active-low pixel map. A double-buffered handshake accepts new frames. The block time-multiplexes the display one column at a time, with a blanking cycle between columns to suppress ghosting.

## Interface
- `DATA_WIDTH`, 35, frame width in bits.
- `COLUNE_SIZE`, 7, rows per column.
- `TOTAL_COLUNES`, 5, number of columns.
- `DWELL_CYCLES`, 50000, clock cycles each column stays lit (must be ≥ 1).
- `clk`  in  1  single system clock.
- `reset`  in  1  synchronous, active-high reset.
- `frame_in`  in  35  pixel map. Bit `c*7+r` is column c (a=0..e=4), row r (row 1 = r0). Pixel is 0 = lit, 1 = dark.
- `frame_valid`  in  1  `frame_in` is offered this cycle.
- `frame_ready`  out  1  shadow buffer is empty and a frame can be accepted.
- `row_out`  out  7  active-low row drive for the selected column.
- `col_sel_n`  out  5  active-low one-hot column select. Bit 0 selects column a.
- `frame_done`  out  1  one-cycle pulse when a full scan of columns a..e completes.

## Operation
- **Storage:** the block holds two 35-bit registers.
  - `shadow` holds the frame just accepted.
  - `active` holds the frame being scanned.
  - A `shadow_full` flag tracks the shadow. `frame_ready = !shadow_full`.
- **Accept:** a frame is accepted on any edge where `frame_valid && frame_ready`. That edge loads `shadow` and sets `shadow_full`. A `frame_valid` asserted while `frame_ready = 0` is ignored, and the shadow is never overwritten.
- **IDLE** (entered at reset):
  - `col_sel_n = 5'b11111`, `row_out = 7'h7F`.
  - If `shadow_full`: copy `shadow` to `active`, clear `shadow_full`, set col = 0, go to BLANK.
- **BLANK** (exactly 1 cycle):
  - `col_sel_n = 5'b11111`, `row_out = 7'h7F`.
  - Next state is SHOW.
- **SHOW:**
  - `col_sel_n = ~(1 << col)`, `row_out = active[col*7 +: 7]`.
  - Lasts DWELL_CYCLES cycles, counted by a dwell counter of width `$clog2(DWELL_CYCLES+1)`.
  - At the end of dwell with col < 4: col++, go to BLANK.
  - At the end of dwell with col = 4:
    - Set col = 0 and go to BLANK.
    - Pulse `frame_done` during that BLANK cycle.
    - If `shadow_full` on that same edge, swap `shadow` into `active` and clear `shadow_full`. Otherwise `active` repeats.
- The block never returns to IDLE except through reset. After the first frame it scans continuously.
- **Swap vs. accept:** these cannot collide. Accept requires an empty shadow and swap requires a full one.
- **Reset mid-operation** (any state):
  - Next edge goes to IDLE, all outputs return to reset values.
  - `shadow_full = 0`; both buffers are set to all ones.

## Timing
- **Reset values:** `col_sel_n = 5'b11111`, `row_out = 7'h7F`, `frame_ready = 1`, `frame_done = 0`.
- All outputs are registered, except `frame_ready`, which is combinational from the `shadow_full` flop.
- **From IDLE:** handshake at edge k, then `shadow_full` is set at k. Edge k+1 enters BLANK and `frame_ready` returns to 1. Edge k+2 shows column a.
- **Frame period:** 5 × (DWELL_CYCLES + 1) cycles.
- `frame_done` rises on the same edge that enters the post-column-e BLANK. The new frame's column a appears one cycle later.
- **Shadow accepted mid-scan:** `frame_ready` stays low until the end-of-frame swap edge, then goes high in the following cycle.

## Structure
- A shared package or header holds:
  - the geometry constants (`DATA_WIDTH`, `COLUNE_SIZE`, `TOTAL_COLUNES`),
  - the state encoding (IDLE = 2'd0, BLANK = 2'd1, SHOW = 2'd2),
  - the all-dark constants `7'h7F` and `5'b11111`.
- Sub-module `dwell_timer`: a parameterised down-counter with `load` and a `expire` pulse, used for the SHOW dwell.
- The top level holds the FSM, column index, buffers and handshake.

## Test plan
All scenarios use `DWELL_CYCLES = 4`.
1. **Reset:** hold `reset` for 3 cycles, `frame_valid = 0` → `col_sel_n = 11111`, `row_out = 7F`, `frame_ready = 1`, `frame_done = 0` indefinitely.
2. **Single frame, all lit:**
   - Stimulus: `frame_in = 35'h0`, valid for 1 cycle at edge k.
   - Required: BLANK at k+1. `col_sel_n = 11110`, `row_out = 00` for 4 cycles from k+2.
   - Then the sequence 11101, 11011, 10111, 01111, each preceded by 1 BLANK.
   - `frame_done` pulses at edge k+26, and the scan repeats.
3. **Mapping:**
   - Stimulus: frame all ones except bit 22 = 0 (column d, row 2).
   - Required: `row_out = 7'b1111101` only while `col_sel_n = 10111`; `7F` in every other column.
4. **Double buffer:**
   - Stimulus: offer frame B (all ones except bit 0) during column b of frame A.
   - Required: `frame_ready` drops. A finishes all 5 columns. B appears starting at the next column a (`row_out = 7E`). `frame_ready` returns to 1 after the swap.
5. **Backpressure:** with the shadow full, assert `frame_valid` with frame C for 10 cycles → C is never displayed, and the shadow still holds B.
6. **Reset mid-scan:** assert `reset` during SHOW of column c → IDLE outputs appear on the next edge, and no display occurs until a new frame is accepted.
